// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between instruction fetch and load/store.
// Define ARB_PERF_CNT_EN to add grant and conflict performance counters.
module imem_dmem_port_arbiter #(
   parameter int MemLatency  = 2,
   parameter int StarveLimit = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [0:31] fetch_addr,
   input  logic        fetch_flush,
   output logic        fetch_gnt,
   output logic        fetch_rvalid,
   output logic [0:31] fetch_rdata,
   output logic        fetch_stall,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [0:31] data_addr,
   input  logic [0:31] data_wdata,
   input  logic [0:3]  data_be,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [0:31] data_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [0:31] mem_addr,
   output logic [0:31] mem_wdata,
   output logic [0:3]  mem_be,
   input  logic [0:31] mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [0:31] perf_fetch_grants,
   output logic [0:31] perf_data_grants,
   output logic [0:31] perf_conflicts
`endif
);

   localparam logic [3:0] LAT_LOAD  = 4'(MemLatency);
   localparam logic [2:0] STARVE_MAX = 3'(StarveLimit);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  lat_cnt_reg;
   logic [2:0]  starve_cnt_reg;
   logic        drop_reg;
   logic        owner_data_reg;
   logic        store_reg;
   logic [0:31] fetch_rdata_reg;
   logic [0:31] data_rdata_reg;

   logic starved;
   logic grant_data;
   logic grant_fetch;
   logic done;

   // Data normally wins (older instruction); fetch is forced through once starved.
   assign starved     = (starve_cnt_reg == STARVE_MAX);
   assign grant_data  = (state_reg == IDLE) && !reset && data_req && !(fetch_req && starved);
   assign grant_fetch = (state_reg == IDLE) && !reset && fetch_req && !grant_data;
   assign done        = (state_reg == BUSY) && !reset && (lat_cnt_reg == 4'd1);

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_fetch || grant_data) state_next = BUSY;
         BUSY:    if (done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fetch_gnt    = grant_fetch;
      data_gnt     = grant_data;
      mem_en       = grant_fetch || grant_data;
      mem_we       = grant_data && data_we;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_be       = '0;
      if (grant_data) begin
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
         mem_be    = data_be;
      end else if (grant_fetch) begin
         mem_addr  = fetch_addr;
         mem_be    = 4'hF;
      end
      // A flush on the completion cycle itself also kills the response.
      fetch_rvalid = done && !owner_data_reg && !(drop_reg || fetch_flush);
      data_rvalid  = done && owner_data_reg;
      fetch_rdata  = fetch_rvalid ? mem_rdata : fetch_rdata_reg;
      data_rdata   = data_rvalid ? (store_reg ? '0 : mem_rdata) : data_rdata_reg;
      fetch_stall  = fetch_req && !fetch_rvalid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_cnt_reg     <= '0;
         starve_cnt_reg  <= '0;
         drop_reg        <= 1'b0;
         owner_data_reg  <= 1'b0;
         store_reg       <= 1'b0;
         fetch_rdata_reg <= '0;
         data_rdata_reg  <= '0;
      end else begin
         if (grant_fetch || grant_data) begin
            lat_cnt_reg    <= LAT_LOAD;
            owner_data_reg <= grant_data;
            store_reg      <= grant_data && data_we;
            drop_reg       <= grant_fetch && fetch_flush;
         end else if (state_reg == BUSY) begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
            if (done)
               drop_reg <= 1'b0;
            else if (!owner_data_reg && fetch_flush)
               drop_reg <= 1'b1;
         end
         if (fetch_rvalid) fetch_rdata_reg <= mem_rdata;
         if (data_rvalid)  data_rdata_reg  <= store_reg ? '0 : mem_rdata;
         if (grant_fetch || !fetch_req)
            starve_cnt_reg <= '0;
         else if (grant_data && !starved)
            starve_cnt_reg <= starve_cnt_reg + 3'd1;
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_grants <= '0;
         perf_data_grants  <= '0;
         perf_conflicts    <= '0;
      end else begin
         if (grant_fetch) perf_fetch_grants <= perf_fetch_grants + 32'd1;
         if (grant_data)  perf_data_grants  <= perf_data_grants + 32'd1;
         if ((state_reg == IDLE) && fetch_req && data_req)
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Bench for imem_dmem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model (grant cycle + latency, starvation count, drop flag).
module tb_imem_dmem_port_arbiter;
   localparam int LAT = 2;
   localparam int LIM = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, fetch_req, fetch_flush, fetch_gnt, fetch_rvalid, fetch_stall;
   logic [0:31] fetch_addr, fetch_rdata;
   logic        data_req, data_we, data_gnt, data_rvalid;
   logic [0:31] data_addr, data_wdata, data_rdata;
   logic [0:3]  data_be;
   logic        mem_en, mem_we;
   logic [0:31] mem_addr, mem_wdata, mem_rdata;
   logic [0:3]  mem_be;

   imem_dmem_port_arbiter #(.MemLatency(LAT), .StarveLimit(LIM)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
      .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .fetch_stall(fetch_stall),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_be(data_be), .data_gnt(data_gnt),
      .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   int cyc, check_cnt, pass_cnt;

   // reference model: one outstanding transaction, finishing at a known cycle
   logic        m_busy, m_owner_data, m_store, m_drop;
   int          m_done, m_starve;
   logic [0:31] m_addr, m_frd, m_drd;

   logic        e_fgnt, e_dgnt, e_frv, e_drv, e_men, e_mwe, e_stall;
   logic [0:31] e_maddr, e_mwdata, e_frd, e_drd;
   logic [0:3]  e_mbe;

   // memory: answers MemLatency cycles after each observed issue
   int          mem_due;
   logic [0:31] mem_val;

   function automatic logic [0:31] memfn(input logic [0:31] a);
      return (a ^ 32'h5A5AC3C3) + 32'h01234567;
   endfunction

   function automatic logic [138:0] obs_vec();
      return {fetch_gnt, fetch_rvalid, fetch_stall, data_gnt, data_rvalid, mem_en, mem_we,
              mem_addr, mem_wdata, mem_be, fetch_rdata, data_rdata};
   endfunction

   function automatic logic [138:0] exp_vec();
      return {e_fgnt, e_frv, e_stall, e_dgnt, e_drv, e_men, e_mwe,
              e_maddr, e_mwdata, e_mbe, e_frd, e_drd};
   endfunction

   task automatic drive(input logic rst, input logic fr, input logic [0:31] fa, input logic ff,
                        input logic dr, input logic dwe, input logic [0:31] da,
                        input logic [0:31] dwd, input logic [0:3] dbe);
      reset = rst; fetch_req = fr; fetch_addr = fa; fetch_flush = ff;
      data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd; data_be = dbe;
      mem_rdata = (cyc == mem_due) ? mem_val : 32'($urandom());
   endtask

   task automatic model_comb();
      e_fgnt = 0; e_dgnt = 0; e_frv = 0; e_drv = 0; e_men = 0; e_mwe = 0;
      e_maddr = '0; e_mwdata = '0; e_mbe = '0; e_frd = m_frd; e_drd = m_drd;
      if (!reset) begin
         if (m_busy && cyc == m_done) begin
            if (m_owner_data) begin
               e_drv = 1; e_drd = m_store ? 32'h0 : memfn(m_addr);
            end else if (!(m_drop || fetch_flush)) begin
               e_frv = 1; e_frd = memfn(m_addr);
            end
         end
         if (!m_busy) begin
            if (data_req && !(fetch_req && m_starve == LIM)) begin
               e_dgnt = 1; e_men = 1; e_mwe = data_we;
               e_maddr = data_addr; e_mwdata = data_wdata; e_mbe = data_be;
            end else if (fetch_req) begin
               e_fgnt = 1; e_men = 1; e_maddr = fetch_addr; e_mbe = 4'hF;
            end
         end
      end
      e_stall = fetch_req && !e_frv;
   endtask

   task automatic model_seq();
      if (mem_en) begin mem_due = cyc + LAT; mem_val = memfn(mem_addr); end
      if (reset) begin
         m_busy = 0; m_drop = 0; m_starve = 0; m_frd = '0; m_drd = '0;
      end else begin
         if (e_frv) m_frd = e_frd;
         if (e_drv) m_drd = e_drd;
         if (m_busy && cyc == m_done) m_busy = 0;
         else if (m_busy && !m_owner_data && fetch_flush) m_drop = 1;
         if (e_fgnt || e_dgnt) begin
            m_busy = 1; m_done = cyc + LAT; m_owner_data = e_dgnt;
            m_store = e_dgnt && data_we; m_addr = e_maddr; m_drop = e_fgnt && fetch_flush;
         end
         if (e_fgnt || !fetch_req) m_starve = 0;
         else if (e_dgnt) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      model_comb();
   endtask

   task automatic advance();
      model_seq();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         drive(i < 3, 0, '0, 0, 0, 0, '0, '0, '0);
         sample();
         check_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else pass_cnt++;
         check_cnt++;
         if (obs_vec() !== '0) $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc, obs_vec());
         else pass_cnt++;
         advance();
      end
   endtask

   task automatic test_fetch_only();
      int tg = -1, tr = -1;
      logic fr = 1;
      for (int i = 0; i < 6; i++) begin
         drive(0, fr, 32'h100, 0, 0, 0, '0, '0, '0);
         sample();
         check_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL fetch_only cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         else pass_cnt++;
         if (fetch_gnt && tg < 0) tg = i;
         if (fetch_rvalid && tr < 0) tr = i;
         if (e_frv) fr = 0;
         advance();
      end
      check_cnt++;
      if (tg !== 0 || tr !== LAT) $display("FAIL fetch_timing gnt=%0d rvalid=%0d exp 0/%0d", tg, tr, LAT);
      else pass_cnt++;
   endtask

   task automatic test_conflict();
      int tdg = -1, tdr = -1, tfg = -1, tfr = -1;
      logic fr = 1, dr = 1;
      for (int i = 0; i < 7; i++) begin
         drive(0, fr, 32'h104, 0, dr, 0, 32'h2000, '0, 4'hF);
         sample();
         check_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL conflict cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         else pass_cnt++;
         if (data_gnt && tdg < 0) tdg = i;
         if (data_rvalid && tdr < 0) tdr = i;
         if (fetch_gnt && tfg < 0) tfg = i;
         if (fetch_rvalid && tfr < 0) tfr = i;
         if (e_dgnt) dr = 0;
         if (e_frv) fr = 0;
         advance();
      end
      check_cnt++;
      if (tdg !== 0 || tdr !== 2 || tfg !== 3 || tfr !== 5)
         $display("FAIL conflict_timing dg=%0d dr=%0d fg=%0d fr=%0d exp 0/2/3/5", tdg, tdr, tfg, tfr);
      else pass_cnt++;
   endtask

   task automatic test_starvation();
      int q[$];
      for (int i = 0; i < 18; i++) begin
         drive(0, i < 16, 32'h300 + 32'(i), 0, i < 16, 0, 32'h4000 + 32'(i), '0, 4'hF);
         sample();
         check_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL starve cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         else pass_cnt++;
         if (fetch_gnt) q.push_back(1);
         else if (data_gnt) q.push_back(0);
         advance();
      end
      for (int k = 0; k < 6; k++) begin
         int got;
         got = (k < q.size()) ? q[k] : -1;
         check_cnt++;
         if (got !== ((k % 3 == 2) ? 1 : 0))
            $display("FAIL starve_order grant%0d got=%0d exp=%0d (1=fetch)", k, got, (k % 3 == 2) ? 1 : 0);
         else pass_cnt++;
      end
   endtask

   task automatic test_store();
      int tdg = -1, tdr = -1;
      logic dr = 1;
      logic [0:31] rd_at_rv = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, '0, 0, dr, 1, 32'h3000, 32'hDEADBEEF, 4'b0011);
         sample();
         check_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL store cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         else pass_cnt++;
         if (data_gnt && tdg < 0) begin
            tdg = i;
            check_cnt++;
            if (mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEADBEEF)
               $display("FAIL store_issue we=%b be=%b wdata=%h exp 1/0011/deadbeef", mem_we, mem_be, mem_wdata);
            else pass_cnt++;
         end
         if (data_rvalid && tdr < 0) begin tdr = i; rd_at_rv = data_rdata; end
         if (e_dgnt) dr = 0;
         advance();
      end
      check_cnt++;
      if (tdr - tdg !== LAT || rd_at_rv !== 32'h0)
         $display("FAIL store_done gnt=%0d rvalid=%0d rdata=%h exp +%0d/0", tdg, tdr, rd_at_rv, LAT);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      int g2 = -1, nrv = 0;
      logic fr;
      for (int i = 0; i < 7; i++) begin
         fr = (i == 0) || (i >= 3 && g2 < 0);
         drive(0, fr, (i < 3) ? 32'h200 : 32'h204, i == 1, 0, 0, '0, '0, '0);
         sample();
         check_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL flush cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         else pass_cnt++;
         if (fetch_rvalid && i < 3) nrv++;
         if (fetch_gnt && i > 0 && g2 < 0) g2 = i;
         advance();
      end
      check_cnt++;
      if (nrv !== 0 || g2 !== 3) $display("FAIL flush_drop rvalids=%0d regrant=%0d exp 0/3", nrv, g2);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int g2 = -1, nrv = 0;
      logic fr;
      for (int i = 0; i < 7; i++) begin
         fr = (i == 0) || (i >= 3 && g2 < 0);
         drive(i == 1, fr, (i < 3) ? 32'h500 : 32'h504, 0, 0, 0, '0, '0, '0);
         sample();
         check_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         else pass_cnt++;
         if (i == 2) begin
            check_cnt++;
            if (obs_vec() !== '0) $display("FAIL reset_mid_zero got=%h exp=0", obs_vec());
            else pass_cnt++;
         end
         if (fetch_rvalid && i < 5) nrv++;
         if (fetch_gnt && i > 0 && g2 < 0) g2 = i;
         advance();
      end
      check_cnt++;
      if (nrv !== 0 || g2 !== 3) $display("FAIL reset_mid_resume rvalids=%0d regrant=%0d exp 0/3", nrv, g2);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic fr = 0, dr = 0, dwe = 0;
      logic [0:31] fa = '0, da = '0, dwd = '0;
      logic [0:3]  dbe = '0;
      for (int i = 0; i < 400; i++) begin
         if (!fr && $urandom_range(99) < 50) begin fr = 1; fa = {$urandom_range(255), 2'b00}; end
         if (!dr && $urandom_range(99) < 40) begin
            dr = 1; dwe = 1'($urandom()); da = 32'($urandom()); dwd = 32'($urandom());
            dbe = 4'($urandom());
         end
         drive($urandom_range(99) < 2, fr, fa, $urandom_range(99) < 10, dr, dwe, da, dwd, dbe);
         sample();
         check_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         else pass_cnt++;
         if (e_fgnt) fr = 0;
         if (e_dgnt) dr = 0;
         advance();
      end
   endtask

   initial begin
      check_cnt = 0; pass_cnt = 0; cyc = 0; mem_due = -1; mem_val = '0;
      m_busy = 0; m_owner_data = 0; m_store = 0; m_drop = 0; m_done = 0; m_starve = 0;
      m_addr = '0; m_frd = '0; m_drd = '0;
      drive(1, 0, '0, 0, 0, 0, '0, '0, '0);
      @(posedge clk);
      #1;
      test_reset();
      test_fetch_only();
      test_conflict();
      test_starvation();
      test_store();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
